alu_load_sequencer: RTL and testbench

- Controller that sequences the ALU wrapper's shared 10-bit load bus.
- Accepts one command (opcode, source operand, destination operand) through a valid/ready handshake.
- Drives the one-hot load strobes (op code, src, dest) in order, waits a programmable settle time, then captures the ALU result and flags.
- Presents the captured result through a valid/ready output handshake; sits between the instruction/control logic and the ALU wrapper.

---
 rtl/alu_load_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_load_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_load_sequencer.sv
// Sequences one ALU command onto the shared 10-bit load bus (op, src, dest),
// waits a settle time, captures result/flags and holds them until consumed.
module alu_load_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          OP_REUSE      = 1'b1,
    localparam int unsigned OP_W   = 8,
    localparam int unsigned DATA_W = 10,
    localparam int unsigned RES_W  = 16,
    localparam int unsigned FLAG_W = 5,
    localparam int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_src,
    input  logic [DATA_W-1:0] cmd_dest,
    output logic [DATA_W-1:0] alu_data,
    output logic              alu_ld_op_code,
    output logic              alu_ld_src,
    output logic              alu_ld_dest,
    input  logic [RES_W-1:0]  alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [FLAG_W-1:0] res_flags,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_OP, S_LD_SRC, S_LD_DEST, S_WAIT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                ld_op_q, ld_op_d, ld_src_q, ld_src_d, ld_dest_q, ld_dest_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [OP_W-1:0]     op_q, op_d, last_op_q, last_op_d;
    logic                last_vld_q, last_vld_d;
    logic [DATA_W-1:0]   src_q, src_d, dest_q, dest_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                res_valid_q, res_valid_d;
    logic [RES_W-1:0]    res_data_q, res_data_d;
    logic [FLAG_W-1:0]   res_flags_q, res_flags_d;
    logic [CNT_W-1:0]    op_count_q;
    logic                op_inc_c;

    // Next-state and next-output logic; strobes/data default to idle-bus values
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        ld_op_d     = 1'b0;
        ld_src_d    = 1'b0;
        ld_dest_d   = 1'b0;
        data_d      = '0;
        op_d        = op_q;
        src_d       = src_q;
        dest_d      = dest_q;
        last_op_d   = last_op_q;
        last_vld_d  = last_vld_q;
        wait_d      = wait_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        op_inc_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    src_d       = cmd_src;
                    dest_d      = cmd_dest;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    // ALU already holds this opcode: go straight to the source load
                    if (OP_REUSE && last_vld_q && (cmd_op == last_op_q)) begin
                        state_d  = S_LD_SRC;
                        ld_src_d = 1'b1;
                        data_d   = cmd_src;
                    end else begin
                        state_d = S_LD_OP;
                        ld_op_d = 1'b1;
                        data_d  = {2'b00, cmd_op};
                    end
                end
            end
            S_LD_OP: begin
                last_op_d  = op_q;
                last_vld_d = 1'b1;
                state_d    = S_LD_SRC;
                ld_src_d   = 1'b1;
                data_d     = src_q;
            end
            S_LD_SRC: begin
                state_d   = S_LD_DEST;
                ld_dest_d = 1'b1;
                data_d    = dest_q;
            end
            S_LD_DEST: begin
                state_d = S_WAIT;
                wait_d  = WAIT_W'(SETTLE_CYCLES - 1);
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    res_data_d  = alu_out;
                    res_flags_d = alu_flags;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_inc_c    = 1'b1;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ld_op_q     <= 1'b0;
            ld_src_q    <= 1'b0;
            ld_dest_q   <= 1'b0;
            data_q      <= '0;
            op_q        <= '0;
            src_q       <= '0;
            dest_q      <= '0;
            last_op_q   <= '0;
            last_vld_q  <= 1'b0;
            wait_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            ld_op_q     <= ld_op_d;
            ld_src_q    <= ld_src_d;
            ld_dest_q   <= ld_dest_d;
            data_q      <= data_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dest_q      <= dest_d;
            last_op_q   <= last_op_d;
            last_vld_q  <= last_vld_d;
            wait_q      <= wait_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            if (op_inc_c) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign alu_ld_op_code = ld_op_q;
    assign alu_ld_src     = ld_src_q;
    assign alu_ld_dest    = ld_dest_q;
    assign alu_data       = data_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_flags      = res_flags_q;
    assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Two sequencer instances (settle 1 and 4) checked every cycle against a
// command-timeline model, plus directed cases with literal expectations.
module tb_alu_load_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %0h want %0h", inst, nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int unsigned S = (gi == 0) ? 1 : 4;

        logic        reset, cmd_valid, cmd_ready, res_valid, res_ready, busy;
        logic [7:0]  cmd_op;
        logic [9:0]  cmd_src, cmd_dest, alu_data;
        logic        alu_ld_op_code, alu_ld_src, alu_ld_dest;
        logic [15:0] alu_out, res_data, op_count;
        logic [4:0]  alu_flags, res_flags;
        bit          chk_en = 1'b0;
        bit          fin = 1'b0;
        logic [15:0] m_ofs = 16'h0;

        alu_load_sequencer #(.SETTLE_CYCLES(S), .OP_REUSE(1'b1)) dut (
            .clk(clk), .reset(reset),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
            .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dest(cmd_dest),
            .alu_data(alu_data), .alu_ld_op_code(alu_ld_op_code),
            .alu_ld_src(alu_ld_src), .alu_ld_dest(alu_ld_dest),
            .alu_out(alu_out), .alu_flags(alu_flags),
            .res_valid(res_valid), .res_ready(res_ready),
            .res_data(res_data), .res_flags(res_flags),
            .busy(busy), .op_count(op_count)
        );

        // Model: m_t counts edges since the accept edge; result lands at edge m_lat
        bit          m_busy, m_skip, m_resv, m_lastv;
        int          m_t, m_lat;
        logic [7:0]  m_op, m_lastop;
        logic [9:0]  m_src, m_dest;
        logic [15:0] m_res, m_cnt;
        logic [4:0]  m_flg;

        always @(posedge clk) begin
            if (reset) begin
                m_busy = 1'b0; m_resv = 1'b0; m_lastv = 1'b0; m_t = 0;
                m_res = '0; m_flg = '0; m_cnt = 16'(16'h0 - m_ofs);
            end else if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1'b1; m_t = 0;
                    m_op = cmd_op; m_src = cmd_src; m_dest = cmd_dest;
                    m_skip = m_lastv && (cmd_op == m_lastop);
                    m_lastop = cmd_op; m_lastv = 1'b1;
                    m_lat = (m_skip ? 2 : 3) + int'(S);
                end
            end else if (m_resv) begin
                if (res_ready) begin
                    m_resv = 1'b0; m_busy = 1'b0; m_cnt++;
                end
            end else begin
                m_t++;
                if (m_t == m_lat) begin
                    m_resv = 1'b1; m_res = alu_out; m_flg = alu_flags;
                end
            end
        end

        always @(negedge clk) begin : cmp
            bit         act, eo, es, ed;
            logic [9:0] edata;
            if (chk_en) begin
                act   = m_busy && !m_resv;
                eo    = act && !m_skip && (m_t == 0);
                es    = act && (m_t == (m_skip ? 0 : 1));
                ed    = act && (m_t == (m_skip ? 1 : 2));
                edata = eo ? {2'b00, m_op} : es ? m_src : ed ? m_dest : 10'h0;
                check("cmd_ready", gi, cmd_ready, !m_busy);
                check("busy", gi, busy, m_busy);
                check("ld_op", gi, alu_ld_op_code, eo);
                check("ld_src", gi, alu_ld_src, es);
                check("ld_dest", gi, alu_ld_dest, ed);
                check("alu_data", gi, alu_data, edata);
                check("res_valid", gi, res_valid, m_resv);
                check("res_data", gi, res_data, m_res);
                check("res_flags", gi, res_flags, m_flg);
                check("op_count", gi, op_count, 16'(m_cnt + m_ofs));
            end
        end

        task automatic send(input logic [7:0] op, input logic [9:0] s, input logic [9:0] d);
            int n = 0;
            cmd_op = op; cmd_src = s; cmd_dest = d; cmd_valid = 1'b1;
            while (!cmd_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("accept", gi, cmd_ready, 1'b1);
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op = 8'($urandom); cmd_src = 10'($urandom); cmd_dest = 10'($urandom);
        endtask

        task automatic to_result(output int lat, output int np);
            lat = 0; np = 0;
            while (!res_valid && lat < 64) begin
                np += int'(alu_ld_op_code);
                @(negedge clk);
                lat++;
            end
        endtask

        task automatic handshake();
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        endtask

        task automatic start();
            reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
            cmd_op = '0; cmd_src = '0; cmd_dest = '0; alu_out = '0; alu_flags = '0;
            @(negedge clk);
            @(negedge clk);
            chk_en = 1'b1;
            check("rst_ready", gi, cmd_ready, 1'b1);
            check("rst_busy", gi, busy, 1'b0);
            check("rst_count", gi, op_count, 16'h0);
            reset = 1'b0;
        endtask

        task automatic random_phase(input int n);
            bit rdy_e, rst_e;
            for (int c = 0; c < n; c++) begin
                if (!cmd_valid) begin
                    cmd_valid = ($urandom_range(0, 3) != 0);
                    cmd_op    = 8'($urandom_range(1, 3));
                    cmd_src   = 10'($urandom);
                    cmd_dest  = 10'($urandom);
                end
                reset     = ($urandom_range(0, 299) == 0);
                res_ready = 1'($urandom_range(0, 1));
                alu_out   = 16'($urandom);
                alu_flags = 5'($urandom);
                rdy_e = cmd_ready;
                rst_e = reset;
                @(negedge clk);
                if (cmd_valid && rdy_e && !rst_e) cmd_valid = 1'b0;
            end
            reset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        endtask

        if (gi == 0) begin : g_dir
            initial begin
                int lat, np;
                start();
                // Basic op with literal bus sequence
                alu_out = 16'h0007; alu_flags = 5'h00;
                send(8'h02, 10'h005, 10'h003);
                check("b1_strb", gi, {alu_ld_op_code, alu_ld_src, alu_ld_dest}, 3'b100);
                check("b1_data", gi, alu_data, 10'h002);
                @(negedge clk);
                check("b2_strb", gi, {alu_ld_op_code, alu_ld_src, alu_ld_dest}, 3'b010);
                check("b2_data", gi, alu_data, 10'h005);
                @(negedge clk);
                check("b3_strb", gi, {alu_ld_op_code, alu_ld_src, alu_ld_dest}, 3'b001);
                check("b3_data", gi, alu_data, 10'h003);
                @(negedge clk);
                check("b4_strb", gi, {alu_ld_op_code, alu_ld_src, alu_ld_dest}, 3'b000);
                check("b4_data", gi, alu_data, 10'h000);
                check("b4_rv", gi, res_valid, 1'b0);
                @(negedge clk);
                check("b_rv", gi, res_valid, 1'b1);
                check("b_res", gi, res_data, 16'h0007);
                check("b_flg", gi, res_flags, 5'h00);
                handshake();
                check("b_cnt", gi, op_count, 16'h0001);
                check("b_ready", gi, cmd_ready, 1'b1);
                // Same opcode reuses the loaded opcode
                send(8'h02, 10'h011, 10'h022);
                to_result(lat, np);
                check("reuse_lat", gi, lat, 3);
                check("reuse_oppulse", gi, np, 0);
                handshake();
                send(8'h05, 10'h033, 10'h044);
                to_result(lat, np);
                check("newop_lat", gi, lat, 4);
                check("newop_oppulse", gi, np, 1);
                handshake();
                // Backpressure in DONE
                alu_out = 16'h1234; alu_flags = 5'h0A;
                send(8'h07, 10'h1AA, 10'h155);
                to_result(lat, np);
                check("bp_lat", gi, lat, 4);
                for (int k = 0; k < 6; k++) begin
                    alu_out = 16'($urandom); alu_flags = 5'($urandom);
                    cmd_valid = 1'b1; cmd_op = 8'h09;
                    @(negedge clk);
                    check("bp_res", gi, res_data, 16'h1234);
                    check("bp_flg", gi, res_flags, 5'h0A);
                    check("bp_rv", gi, res_valid, 1'b1);
                    check("bp_ready", gi, cmd_ready, 1'b0);
                end
                cmd_valid = 1'b0;
                handshake();
                check("bp_idle_ready", gi, cmd_ready, 1'b1);
                check("bp_idle_busy", gi, busy, 1'b0);
                check("bp_cnt", gi, op_count, 16'h0004);
                // Reset during LD_SRC (opcode 7 is reused, so cycle 1 is LD_SRC)
                send(8'h07, 10'h0AA, 10'h0BB);
                check("r_ldsrc", gi, {alu_ld_op_code, alu_ld_src, alu_ld_dest}, 3'b010);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("r_strb", gi, {alu_ld_op_code, alu_ld_src, alu_ld_dest}, 3'b000);
                check("r_ready", gi, cmd_ready, 1'b1);
                check("r_rv", gi, res_valid, 1'b0);
                check("r_cnt", gi, op_count, 16'h0000);
                send(8'h07, 10'h0AA, 10'h0BB);
                to_result(lat, np);
                check("r_oppulse", gi, np, 1);
                check("r_lat", gi, lat, 4);
                handshake();
                // Counter wrap
                m_ofs = 16'(16'hFFFF - m_cnt);
                force dut.op_count_q = 16'hFFFF;
                @(negedge clk);
                release dut.op_count_q;
                check("w_pre", gi, op_count, 16'hFFFF);
                send(8'h01, 10'h001, 10'h002);
                to_result(lat, np);
                handshake();
                check("w_wrap", gi, op_count, 16'h0000);
                random_phase(3000);
                fin = 1'b1;
            end
        end else begin : g_dir
            initial begin
                int lat, np;
                start();
                send(8'h03, 10'h00A, 10'h014);
                lat = 0;
                // alu_out tags each cycle so the captured cycle is identifiable
                while (!res_valid && lat < 64) begin
                    alu_out   = 16'h0100 + 16'(lat + 1);
                    alu_flags = 5'(lat + 1);
                    @(negedge clk);
                    lat++;
                end
                check("s_lat", gi, lat, 7);
                check("s_res", gi, res_data, 16'h0107);
                check("s_flg", gi, res_flags, 5'h07);
                handshake();
                check("s_cnt", gi, op_count, 16'h0001);
                alu_out = 16'h0055;
                send(8'h03, 10'h001, 10'h001);
                to_result(lat, np);
                check("s_reuse_lat", gi, lat, 6);
                check("s_reuse_oppulse", gi, np, 0);
                handshake();
                random_phase(3000);
                fin = 1'b1;
            end
        end
    end

    initial begin
        int n = 0;
        while (!(g_dut[0].fin && g_dut[1].fin) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("all_done", 0, {g_dut[0].fin, g_dut[1].fin}, 2'b11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
